// File: rtl/isp_remosaic.sv
// isp_remosaic: RGB pixel stream to single-channel Bayer RAW with a fixed 2-clock pipeline.
// Define ISP_REMOSAIC_CHK_EN to build the line/frame geometry checker (error outputs tie to 0 otherwise).
module isp_remosaic #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960,
  parameter int BAYER  = 0
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_r,
  input  logic [BITS-1:0] in_g,
  input  logic [BITS-1:0] in_b,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_raw,
  output logic            out_line_err,
  output logic            out_frame_err
);

  localparam logic FLIP_LINE = (BAYER == 2) || (BAYER == 3);
  localparam logic FLIP_PIX  = (BAYER == 1) || (BAYER == 3);

  if (BAYER < 0 || BAYER > 3 || WIDTH < 1 || WIDTH > 65535 ||
      HEIGHT < 1 || HEIGHT > 65535) begin : g_bad_param
    $error("isp_remosaic: BAYER must be 0..3 and WIDTH/HEIGHT must fit 16 bits");
  end

  logic            odd_pix;
  logic            odd_line;
  logic [1:0]      fmt;
  logic            href_fall;

  logic [BITS-1:0] s1_r;
  logic [BITS-1:0] s1_g;
  logic [BITS-1:0] s1_b;
  logic            s1_href;
  logic            s1_vsync;
  logic [1:0]      s1_fmt;
  logic [BITS-1:0] sel;

  logic [BITS-1:0] s2_raw;
  logic            s2_href;
  logic            s2_vsync;

  // Stage-1 href/vsync double as the previous-cycle copies for edge detection.
  assign href_fall = s1_href & ~in_href;
  assign fmt       = {odd_line ^ FLIP_LINE, odd_pix ^ FLIP_PIX};

  always_comb begin
    sel = s1_g;
    case (s1_fmt)
      2'b00:   sel = s1_b;
      2'b11:   sel = s1_r;
      default: sel = s1_g;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      odd_pix  <= 1'b0;
      odd_line <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_href  <= 1'b0;
      s1_vsync <= 1'b0;
      s1_fmt   <= 2'b00;
      s2_raw   <= '0;
      s2_href  <= 1'b0;
      s2_vsync <= 1'b0;
    end else begin
      odd_pix <= in_href ? ~odd_pix : 1'b0;
      if (in_vsync) begin
        odd_line <= 1'b0;
      end else if (href_fall) begin
        odd_line <= ~odd_line;
      end
      s1_r     <= in_r;
      s1_g     <= in_g;
      s1_b     <= in_b;
      s1_href  <= in_href;
      s1_vsync <= in_vsync;
      s1_fmt   <= fmt;
      // Gate here so out_raw is a clean register and reads 0 outside active lines.
      s2_raw   <= s1_href ? sel : '0;
      s2_href  <= s1_href;
      s2_vsync <= s1_vsync;
    end
  end

  assign out_href  = s2_href;
  assign out_vsync = s2_vsync;
  assign out_raw   = s2_raw;

`ifdef ISP_REMOSAIC_CHK_EN
  localparam logic [15:0] WIDTH_L  = 16'(WIDTH);
  localparam logic [15:0] HEIGHT_L = 16'(HEIGHT);

  logic [15:0] pix_cnt;
  logic [15:0] line_cnt;
  logic [15:0] line_cnt_nxt;
  logic        line_open;
  logic        vsync_seen;
  logic        frame_active;
  logic        href_rise;
  logic        vsync_rise;
  logic        line_err_s1;
  logic        frame_err_s1;
  logic        line_err_q;
  logic        frame_err_q;

  assign href_rise    = in_href & ~s1_href;
  assign vsync_rise   = in_vsync & ~s1_vsync;
  assign line_cnt_nxt = (href_fall && line_cnt != 16'hFFFF) ? line_cnt + 16'd1 : line_cnt;

  // line_open only sets on an observed href rise, so a line cut by reset is never judged.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      pix_cnt      <= '0;
      line_cnt     <= '0;
      line_open    <= 1'b0;
      vsync_seen   <= 1'b0;
      frame_active <= 1'b0;
      line_err_s1  <= 1'b0;
      frame_err_s1 <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (in_href) begin
        if (pix_cnt != 16'hFFFF) begin
          pix_cnt <= pix_cnt + 16'd1;
        end
      end else if (href_fall) begin
        pix_cnt <= '0;
      end

      if (href_rise) begin
        line_open <= 1'b1;
      end else if (href_fall) begin
        line_open <= 1'b0;
      end

      if (in_vsync) begin
        vsync_seen <= 1'b1;
      end

      line_err_s1  <= href_fall && line_open && (pix_cnt != WIDTH_L);
      frame_err_s1 <= vsync_rise && frame_active && (line_cnt_nxt != HEIGHT_L);

      if (vsync_rise) begin
        line_cnt     <= '0;
        frame_active <= 1'b0;
      end else begin
        line_cnt <= line_cnt_nxt;
        if (href_rise && vsync_seen) begin
          frame_active <= 1'b1;
        end
      end

      // Second register aligns the pulses with the stage-2 syncs.
      line_err_q  <= line_err_s1;
      frame_err_q <= frame_err_s1;
    end
  end

  assign out_line_err  = line_err_q;
  assign out_frame_err = frame_err_q;
`else
  assign out_line_err  = 1'b0;
  assign out_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_isp_remosaic.sv
// tb_isp_remosaic: four instances (one per BAYER pattern) driven by a shared 4x2 stimulus;
// expected RAW samples and error pulses are queued by the driver and checked by a monitor.
module tb_isp_remosaic;

  localparam int W = 4;
  localparam int H = 2;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       in_href;
  logic       in_vsync;
  logic [7:0] in_r;
  logic [7:0] in_g;
  logic [7:0] in_b;
  logic       o_href  [4];
  logic       o_vsync [4];
  logic       o_lerr  [4];
  logic       o_ferr  [4];
  logic [7:0] o_raw   [4];

  typedef struct {
    int         stamp;
    logic [7:0] raw;
  } pix_t;

  pix_t exp_q [4][$];
  int   lerr_q[$];
  int   ferr_q[$];
  int   chan_tab [4][4];   // [bayer][line_par*2+pix_par]: 0=b 1=g 2=r
  int   ecnt  = 0;
  int   total = 0;
  int   bad   = 0;
  logic vs_d1 = 1'b0;
  logic vs_d2 = 1'b0;
  logic mon_en = 1'b0;

  logic m_prev_href, m_prev_vs, m_lo, m_line_open, m_fa, m_vseen, skip_push;
  int   m_pix, m_lc;

  logic exp_l, exp_f;
  pix_t e;

  always #5 pclk = ~pclk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    isp_remosaic #(.BITS(8), .WIDTH(W), .HEIGHT(H), .BAYER(gi)) u_dut (
      .pclk         (pclk),
      .rst_n        (rst_n),
      .in_href      (in_href),
      .in_vsync     (in_vsync),
      .in_r         (in_r),
      .in_g         (in_g),
      .in_b         (in_b),
      .out_href     (o_href[gi]),
      .out_vsync    (o_vsync[gi]),
      .out_raw      (o_raw[gi]),
      .out_line_err (o_lerr[gi]),
      .out_frame_err(o_ferr[gi])
    );
  end

  always @(posedge pclk) begin
    ecnt++;
    if (!rst_n) begin
      vs_d2 = 1'b0;
      vs_d1 = 1'b0;
    end else begin
      vs_d2 = vs_d1;
      vs_d1 = in_vsync;
    end
  end

  always @(negedge pclk) begin
    if (mon_en) begin
      exp_l = (lerr_q.size() > 0) && (lerr_q[0] == ecnt);
      exp_f = (ferr_q.size() > 0) && (ferr_q[0] == ecnt);
      for (int i = 0; i < 4; i++) begin
        total++;
        if (o_href[i] === 1'b1) begin
          if (exp_q[i].size() == 0) begin
            bad++;
            $display("FAIL pix_unexpected inst=%0d cyc=%0d got raw=%h want no output", i, ecnt, o_raw[i]);
          end else begin
            e = exp_q[i].pop_front();
            if (e.stamp != ecnt || e.raw !== o_raw[i]) begin
              bad++;
              $display("FAIL pix inst=%0d got raw=%h at cyc %0d want raw=%h at cyc %0d",
                       i, o_raw[i], ecnt, e.raw, e.stamp);
            end
          end
        end else begin
          if (o_raw[i] !== 8'h00 || o_href[i] !== 1'b0) begin
            bad++;
            $display("FAIL raw_idle inst=%0d cyc=%0d got href=%b raw=%h want href=0 raw=00",
                     i, ecnt, o_href[i], o_raw[i]);
          end
          if (exp_q[i].size() > 0 && exp_q[i][0].stamp <= ecnt) begin
            total++;
            bad++;
            $display("FAIL pix_missing inst=%0d cyc=%0d got href=0 want raw=%h at cyc %0d",
                     i, ecnt, exp_q[i][0].raw, exp_q[i][0].stamp);
            void'(exp_q[i].pop_front());
          end
        end
        total++;
        if (o_vsync[i] !== vs_d2) begin
          bad++;
          $display("FAIL vsync inst=%0d cyc=%0d got=%b want=%b", i, ecnt, o_vsync[i], vs_d2);
        end
        total++;
        if (o_lerr[i] !== exp_l) begin
          bad++;
          $display("FAIL line_err inst=%0d cyc=%0d got=%b want=%b", i, ecnt, o_lerr[i], exp_l);
        end
        total++;
        if (o_ferr[i] !== exp_f) begin
          bad++;
          $display("FAIL frame_err inst=%0d cyc=%0d got=%b want=%b", i, ecnt, o_ferr[i], exp_f);
        end
      end
      if (exp_l) void'(lerr_q.pop_front());
      if (exp_f) void'(ferr_q.pop_front());
    end
  end

  function automatic logic [7:0] pick(input int inst, input logic lo, input int pix,
                                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int c;
    c = chan_tab[inst][(lo ? 2 : 0) + (pix % 2)];
    return (c == 0) ? b : (c == 1) ? g : r;
  endfunction

  task automatic model_clear();
    m_prev_href = 1'b0;
    m_prev_vs   = 1'b0;
    m_lo        = 1'b0;
    m_line_open = 1'b0;
    m_fa        = 1'b0;
    m_vseen     = 1'b0;
    m_pix       = 0;
    m_lc        = 0;
  endtask

  task automatic drive(input logic h, input logic v,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    in_href  = h;
    in_vsync = v;
    in_r     = r;
    in_g     = g;
    in_b     = b;
    if (h && !m_prev_href) begin
      m_pix       = 0;
      m_line_open = 1'b1;
      if (m_vseen) m_fa = 1'b1;
    end
    if (h) begin
      if (!skip_push) begin
        for (int i = 0; i < 4; i++) exp_q[i].push_back('{ecnt + 2, pick(i, m_lo, m_pix, r, g, b)});
      end
      m_pix++;
    end
    if (!h && m_prev_href) begin
`ifdef ISP_REMOSAIC_CHK_EN
      if (m_line_open && m_pix != W) lerr_q.push_back(ecnt + 2);
`endif
      m_lc++;
      m_lo        = ~m_lo;
      m_line_open = 1'b0;
    end
    if (v && !m_prev_vs) begin
`ifdef ISP_REMOSAIC_CHK_EN
      if (m_fa && m_lc != H) ferr_q.push_back(ecnt + 2);
`endif
      m_lc = 0;
      m_fa = 1'b0;
    end
    if (v) begin
      m_lo    = 1'b0;
      m_vseen = 1'b1;
    end
    m_prev_href = h;
    m_prev_vs   = v;
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n    = 1'b0;
    in_href  = 1'b0;
    in_vsync = 1'b0;
    in_r     = '0;
    in_g     = '0;
    in_b     = '0;
    model_clear();
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic vsync_pulse();
    drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic line(input int npx, input bit rnd);
    logic [7:0] r, g, b;
    for (int p = 0; p < npx; p++) begin
      r = rnd ? 8'($urandom_range(0, 255)) : 8'h30;
      g = rnd ? 8'($urandom_range(0, 255)) : 8'h20;
      b = rnd ? 8'($urandom_range(0, 255)) : 8'h10;
      drive(1'b1, 1'b0, r, g, b);
    end
    repeat (3) drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    chan_tab[0] = '{0, 1, 1, 2};   // BGGR
    chan_tab[1] = '{1, 0, 2, 1};   // GBRG
    chan_tab[2] = '{1, 2, 0, 1};   // GRBG
    chan_tab[3] = '{2, 1, 1, 0};   // RGGB
    skip_push = 1'b0;
    rst_n     = 1'b0;
    in_href   = 1'b0;
    in_vsync  = 1'b0;
    in_r      = '0;
    in_g      = '0;
    in_b      = '0;
    model_clear();
    @(posedge pclk);
    #1;
    mon_en = 1'b1;
    do_reset(2);
    repeat (2) drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    // constant-colour 4x2 frame; first vsync after reset
    vsync_pulse();
    line(W, 1'b0);
    line(W, 1'b0);

    // 5-pixel line then a correct line
    vsync_pulse();
    line(5, 1'b0);
    line(W, 1'b0);

    // three-line frame closed by the next vsync
    vsync_pulse();
    line(W, 1'b0);
    line(W, 1'b0);
    line(W, 1'b0);
    vsync_pulse();

    // reset on pixel 2: pixel 1 is still in the pipe when reset lands
    drive(1'b1, 1'b0, 8'h30, 8'h20, 8'h10);
    skip_push = 1'b1;
    drive(1'b1, 1'b0, 8'h30, 8'h20, 8'h10);
    skip_push = 1'b0;
    do_reset(1);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    vsync_pulse();
    line(W, 1'b0);
    line(W, 1'b0);
    vsync_pulse();

    // random RGB, three frames
    for (int f = 0; f < 3; f++) begin
      line(W, 1'b1);
      line(W, 1'b1);
      vsync_pulse();
    end

    repeat (6) drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge pclk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
